// File: rtl/lcd_pkg.sv
// Shared constants for the LCD command path: command bytes, sequencer state codes, db word layout.
// Nothing here holds state.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ADDR_L1  = 8'h80;
    localparam logic [7:0] LCD_ADDR_L2  = 8'hC0;

    localparam int DB_W  = 10;
    localparam int DB_RS = 9;
    localparam int DB_RW = 8;

    localparam logic [5:0] STEP_CLEAR   = 6'd3;
    localparam logic [5:0] STEP_ADDR_L1 = 6'd4;
    localparam logic [5:0] STEP_ADDR_L2 = 6'd21;
    localparam logic [5:0] STEP_LAST    = 6'd37;

    // INIT_NIB is split into setup / E-high / hold / gap phases.
    localparam logic [3:0] S_PWR_WAIT  = 4'd0;
    localparam logic [3:0] S_NIB_SETUP = 4'd1;
    localparam logic [3:0] S_NIB_PULSE = 4'd2;
    localparam logic [3:0] S_NIB_HOLD  = 4'd3;
    localparam logic [3:0] S_NIB_GAP   = 4'd4;
    localparam logic [3:0] S_ISSUE     = 4'd5;
    localparam logic [3:0] S_WAIT      = 4'd6;
    localparam logic [3:0] S_CLR_WAIT  = 4'd7;
    localparam logic [3:0] S_FIN       = 4'd8;

    function automatic logic [DB_W-1:0] make_db(input logic rs, input logic [7:0] data);
        logic [DB_W-1:0] w;
        w        = '0;
        w[DB_RS] = rs;
        w[DB_RW] = 1'b0;
        w[7:0]   = data;
        return w;
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic int unsigned tmax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational 32-character message store; idx 0..15 is line 1, 16..31 is line 2.
// Zero latency, no flow control.
module lcd_msg_rom (
    input  logic [4:0] idx,
    output logic [7:0] ch
);

    // First character sits in the top byte of the packed string.
    localparam logic [255:0] MSG = "Hello, FPGA LCD!4-bit sequencer ";

    logic [4:0] rev;

    always_comb begin
        rev = 5'd31 - idx;
        ch  = MSG[{rev, 3'b000} +: 8];
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD power-on nibble init, then 38 command/character words over a next_instruction/done handshake.
// Next word issues 2 cycles after done (1 idle cycle); Clear adds T_CLEAR cycles; done is the only backpressure.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_4MS     = 205000,
    parameter int unsigned T_100US   = 5000,
    parameter int unsigned T_40US    = 2000,
    parameter int unsigned T_PULSE   = 12,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            done,
    output logic            next_instruction,
    output logic [DB_W-1:0] db,
    output logic [3:0]      init_sf_d,
    output logic            init_lcd_e,
    output logic            init_active,
    output logic            finished
);

    localparam int unsigned T_MAX = tmax(tmax(tmax(T_POWERON, T_4MS), tmax(T_100US, T_40US)),
                                         tmax(T_PULSE, T_CLEAR));
    localparam int CW = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] C_PWR   = CW'(T_POWERON - 1);
    localparam logic [CW-1:0] C_4MS   = CW'(T_4MS - 1);
    localparam logic [CW-1:0] C_100US = CW'(T_100US - 1);
    localparam logic [CW-1:0] C_40US  = CW'(T_40US - 1);
    localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] C_CLEAR = CW'(T_CLEAR - 1);

    logic [3:0]      state;
    logic [CW-1:0]   cnt;
    logic [1:0]      nib;
    logic [5:0]      step;
    logic [4:0]      msg_idx;
    logic [7:0]      msg_char;
    logic [CW-1:0]   gap_last;
    logic [DB_W-1:0] step_word;

    lcd_msg_rom u_rom (
        .idx (msg_idx),
        .ch  (msg_char)
    );

    always_comb begin
        // Line 2 characters sit one step further on, past the second address command.
        msg_idx = (step < STEP_ADDR_L2) ? 5'(step - 6'd5) : 5'(step - 6'd6);

        case (nib)
            2'd0:    gap_last = C_4MS;
            2'd1:    gap_last = C_100US;
            default: gap_last = C_40US;
        endcase

        case (step)
            6'd0:         step_word = make_db(1'b0, LCD_FUNC_SET);
            6'd1:         step_word = make_db(1'b0, LCD_ENTRY);
            6'd2:         step_word = make_db(1'b0, LCD_DISP_ON);
            STEP_CLEAR:   step_word = make_db(1'b0, LCD_CLEAR);
            STEP_ADDR_L1: step_word = make_db(1'b0, LCD_ADDR_L1);
            STEP_ADDR_L2: step_word = make_db(1'b0, LCD_ADDR_L2);
            default:      step_word = make_db(1'b1, msg_char);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_PWR_WAIT;
            cnt              <= '0;
            nib              <= 2'd0;
            step             <= 6'd0;
            next_instruction <= 1'b0;
            db               <= '0;
            init_sf_d        <= 4'h0;
            init_lcd_e       <= 1'b0;
            init_active      <= 1'b1;
            finished         <= 1'b0;
        end else begin
            next_instruction <= 1'b0;
            case (state)
                S_PWR_WAIT: begin
                    if (cnt == C_PWR) begin
                        cnt       <= '0;
                        nib       <= 2'd0;
                        init_sf_d <= init_nibble(2'd0);
                        state     <= S_NIB_SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NIB_SETUP: begin
                    init_lcd_e <= 1'b1;
                    cnt        <= '0;
                    state      <= S_NIB_PULSE;
                end
                S_NIB_PULSE: begin
                    if (cnt == C_PULSE) begin
                        init_lcd_e <= 1'b0;
                        state      <= S_NIB_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NIB_HOLD: begin
                    cnt   <= '0;
                    state <= S_NIB_GAP;
                end
                S_NIB_GAP: begin
                    if (cnt == gap_last) begin
                        cnt <= '0;
                        if (nib == 2'd3) begin
                            init_active <= 1'b0;
                            init_sf_d   <= 4'h0;
                            state       <= S_ISSUE;
                        end else begin
                            nib       <= nib + 1'b1;
                            init_sf_d <= init_nibble(nib + 1'b1);
                            state     <= S_NIB_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    db               <= step_word;
                    next_instruction <= 1'b1;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    // A done coinciding with the issue pulse cannot belong to this word.
                    if (done && !next_instruction) begin
                        if (step == STEP_CLEAR) begin
                            cnt   <= '0;
                            state <= S_CLR_WAIT;
                        end else if (step == STEP_LAST) begin
                            finished <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            step  <= step + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_CLR_WAIT: begin
                    if (cnt == C_CLEAR) begin
                        step  <= step + 1'b1;
                        state <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    finished <= 1'b1;
                end
                default: state <= S_PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with shortened timers and a done responder 15 cycles after each issue.
module tb_lcd_cmd_sequencer;

    localparam int T_POWERON = 20;
    localparam int T_4MS     = 10;
    localparam int T_100US   = 6;
    localparam int T_40US    = 4;
    localparam int T_PULSE   = 3;
    localparam int T_CLEAR   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       done = 1'b0;
    logic       next_instruction;
    logic [9:0] db;
    logic [3:0] init_sf_d;
    logic       init_lcd_e;
    logic       init_active;
    logic       finished;

    int n_checks = 0;
    int n_fail   = 0;
    string msg = "Hello, FPGA LCD!4-bit sequencer ";

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .T_POWERON (T_POWERON),
        .T_4MS     (T_4MS),
        .T_100US   (T_100US),
        .T_40US    (T_40US),
        .T_PULSE   (T_PULSE),
        .T_CLEAR   (T_CLEAR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .done             (done),
        .next_instruction (next_instruction),
        .db               (db),
        .init_sf_d        (init_sf_d),
        .init_lcd_e       (init_lcd_e),
        .init_active      (init_active),
        .finished         (finished)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_word(input int s);
        byte c;
        case (s)
            0:  return 10'h028;
            1:  return 10'h006;
            2:  return 10'h00C;
            3:  return 10'h001;
            4:  return 10'h080;
            21: return 10'h0C0;
            default: begin
                c = msg[(s < 21) ? s - 5 : s - 6];
                return {2'b10, c};
            end
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ni"},     32'(next_instruction), 32'h0);
        chk({tag, "_db"},     32'(db),               32'h0);
        chk({tag, "_sfd"},    32'(init_sf_d),        32'h0);
        chk({tag, "_e"},      32'(init_lcd_e),       32'h0);
        chk({tag, "_active"}, 32'(init_active),      32'h1);
        chk({tag, "_fin"},    32'(finished),         32'h0);
    endtask

    task automatic run_init(input bit spurious);
        int t;
        int w;
        int gaps[4] = '{T_4MS, T_100US, T_40US, T_40US};
        logic [3:0] nibs[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
        bit bad = 1'b0;
        for (int n = 0; n < 4; n++) begin
            t = 0;
            while (init_lcd_e !== 1'b1 && t < 1000) begin
                if (spurious && n == 0 && t == 5) done = 1'b1;
                tick();
                t++;
                done = 1'b0;
                if (next_instruction !== 1'b0 || init_active !== 1'b1) bad = 1'b1;
            end
            chk($sformatf("e_rise_delay%0d", n), 32'(t),
                32'((n == 0) ? T_POWERON + 1 : gaps[n-1] + 2));
            chk($sformatf("sfd_at_rise%0d", n), 32'(init_sf_d), 32'(nibs[n]));
            w = 0;
            while (init_lcd_e === 1'b1 && w < 100) begin
                tick();
                w++;
                if (next_instruction !== 1'b0 || init_active !== 1'b1) bad = 1'b1;
            end
            chk($sformatf("e_width%0d", n), 32'(w), 32'(T_PULSE));
            chk($sformatf("sfd_hold%0d", n), 32'(init_sf_d), 32'(nibs[n]));
        end
        chk("init_phase_quiet", 32'(bad), 32'h0);
    endtask

    task automatic run_cmds(input int last_step, input bit spurious, input bit reset_at_last);
        int t;
        int exp_gap;
        bit stable;
        for (int s = 0; s <= last_step; s++) begin
            exp_gap = (s == 0) ? T_40US + 2 : (s == 4) ? T_CLEAR + 1 : 1;
            t = 0;
            while (next_instruction !== 1'b1 && t < 200) begin
                if (spurious && s == 4 && t == 3) done = 1'b1;
                tick();
                t++;
                done = 1'b0;
            end
            chk($sformatf("ni_gap_step%0d", s), 32'(t), 32'(exp_gap));
            chk($sformatf("db_step%0d", s), 32'(db), 32'(exp_word(s)));
            chk($sformatf("active_step%0d", s), 32'(init_active), 32'h0);
            chk($sformatf("fin_step%0d", s), 32'(finished), 32'h0);
            if (reset_at_last && s == last_step) begin
                reset = 1'b0;
                #2;
                chk_reset_vals("async_reset");
                return;
            end
            if (spurious && s == 7) done = 1'b1;
            tick();
            done = 1'b0;
            chk($sformatf("ni_width_step%0d", s), 32'(next_instruction), 32'h0);
            stable = 1'b1;
            repeat (13) begin
                tick();
                if (db !== exp_word(s) || next_instruction !== 1'b0) stable = 1'b0;
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            chk($sformatf("db_stable_step%0d", s), 32'(stable), 32'h1);
        end
    endtask

    task automatic check_fin();
        bit quiet = 1'b1;
        chk("finished_after_last_done", 32'(finished), 32'h1);
        repeat (30) begin
            tick();
            if (next_instruction !== 1'b0 || db !== exp_word(37) || finished !== 1'b1) quiet = 1'b0;
        end
        chk("fin_terminal", 32'(quiet), 32'h1);
    endtask

    initial begin
        reset = 1'b0;
        done  = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // Run 1: spurious done pulses in PWR_WAIT, CLR_WAIT and coincident with an issue pulse.
        reset = 1'b1;
        run_init(1'b1);
        run_cmds(37, 1'b1, 1'b0);
        check_fin();

        // Run 2: reset asserted asynchronously while step 10 is outstanding.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        run_init(1'b0);
        run_cmds(10, 1'b0, 1'b1);
        tick();
        chk_reset_vals("held_reset");

        // Run 3: full clean sequence from PWR_WAIT after the mid-run reset.
        reset = 1'b1;
        run_init(1'b0);
        run_cmds(37, 1'b0, 1'b0);
        check_fin();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Upstream stage of the 4-bit LCD instruction transmitter. It runs the display power-on init nibble sequence and then issues the configuration commands. It then writes a 32-character, two-line message as 10-bit {RS,RW,data} words over a next_instruction/done handshake. During init, its own nibble outputs drive the display through a top-level mux selected by init_active.

Parameters:
T_POWERON, 750000, cycles before the first init nibble (15 ms @ 50 MHz)
T_4MS, 205000, gap after init nibble 0
T_100US, 5000, gap after init nibble 1
T_40US, 2000, gap after init nibbles 2 and 3
T_PULSE, 12, width of init_lcd_e high, in cycles
T_CLEAR, 82000, extra wait after the Clear Display command completes (1.64 ms)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
done  input  1  one-cycle pulse from the transmitter when the current word is fully sent
next_instruction  output  1  one-cycle pulse meaning "db is valid, start transmission"
db  output  10  command word: [9]=RS, [8]=RW (always 0), [7:0]=data
init_sf_d  output  4  init nibble data
init_lcd_e  output  1  init nibble enable strobe
init_active  output  1  1 = the top mux selects init_sf_d/init_lcd_e and forces RS=RW=0
finished  output  1  level; goes high once the whole message has been written

Behaviour:
- Reset values (async, applied immediately, including mid-operation): next_instruction=0, db=0, init_sf_d=0, init_lcd_e=0, init_active=1, finished=0. After reset releases, the sequence restarts at PWR_WAIT.
- States:
  - PWR_WAIT: count T_POWERON cycles.
  - INIT_NIB: four nibbles, in order 0x3, 0x3, 0x3, 0x2.
    - init_sf_d is set on entry to each nibble.
    - init_lcd_e rises 1 cycle later and stays high for T_PULSE cycles.
    - init_sf_d is held 1 cycle after init_lcd_e falls.
    - The gap counter then runs: T_4MS, T_100US, T_40US, T_40US for nibbles 0..3.
  - After nibble 3's gap, init_active drops to 0 and the state becomes ISSUE.
  - ISSUE: db is loaded from the step index and next_instruction pulses for exactly 1 cycle, in the same cycle db is first valid. Go to WAIT.
  - WAIT: db is held stable. On done=1:
    - if the step is Clear, go to CLR_WAIT;
    - else if it is the last step, go to FIN;
    - else increment the step and go to ISSUE on the next cycle. The minimum gap from done to the next next_instruction is 1 cycle.
  - CLR_WAIT: count T_CLEAR cycles, increment the step, go to ISSUE.
  - FIN: finished=1 and db is held. Terminal state until reset.
- Step list (36 steps, index 0..35):
  - 0: 0x028 Function Set
  - 1: 0x006 Entry Mode
  - 2: 0x00C Display On
  - 3: 0x001 Clear
  - 4: 0x080 Set DDRAM addr 0x00
  - 5..20: {2'b10, msg[0..15]}
  - 21: 0x0C0 Set DDRAM addr 0x40
  - 22..35: {2'b10, msg[16..29]}
- Correction: the list above yields 36 steps but stops at msg[29]. The message is 32 chars, so the list is extended to steps 22..37 = msg[16..31]. Total is 38 steps; the last step index is 37.
- A done pulse outside WAIT is ignored. A done in the same cycle as next_instruction is ignored; the transmitter cannot finish in 0 cycles.
- Every counter is sized to hold its parameter. Timers count from 0 to T-1 and then advance (exact duration = T cycles).
- next_instruction is never asserted while init_active=1.

Decomposition:
- Shared package lcd_pkg:
  - command constants: LCD_FUNC_SET=8'h28, LCD_ENTRY=8'h06, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ADDR_L1=8'h80, LCD_ADDR_L2=8'hC0;
  - state encoding;
  - the db field layout (RS bit 9, RW bit 8).
- One sub-module: lcd_msg_rom, combinational 5-bit index → 8-bit ASCII, holding the 32-char message.

Test Plan:
Bench parameters: T_POWERON=20, T_4MS=10, T_100US=6, T_40US=4, T_PULSE=3, T_CLEAR=8. A responder model pulses done 15 cycles after each next_instruction.
- Reset released → init_active=1; first init_lcd_e rise 21 cycles later with init_sf_d=0x3; exactly 4 E pulses (0x3,0x3,0x3,0x2), each 3 cycles wide, with gaps of 10/6/4/4 cycles.
- After init → first next_instruction with db=10'h028, then 10'h006, 10'h00C, 10'h001. Each pulse lasts 1 cycle; db is stable until done; next pulse comes 1 cycle after done.
- Clear step → after its done, no next_instruction for 8 cycles; then db=10'h080.
- Message → 32 words with db[9:8]=2'b10 matching the ROM, with 10'h0C0 between char 15 and char 16. finished=1 after the 38th done; no further pulses.
- Spurious done pulses injected during PWR_WAIT and CLR_WAIT → no step advance; the sequence is identical to the clean run.
- reset asserted during the WAIT of step 10 → next_instruction=0, db=0, init_active=1 immediately (asynchronous). After release the full sequence repeats from PWR_WAIT.
